// File: rtl/irq_source_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : irq_source_conditioner
//  Purpose  : Conditions raw, asynchronous, possibly glitchy interrupt lines
//             for the PLIC interrupts_i vector. Per line: polarity
//             normalisation, multi-flop synchronisation into clk_i, and a
//             stability filter. Output is a registered active-high level,
//             gated by a per-line mask. Line 0 is reserved and held at 0.
//  Options  : IRQ_SYNC_3FF_EN - adds a third synchroniser stage (+1 edge
//             latency on every path).
//  Revision : 1.0 - initial release
// ============================================================================
module irq_source_conditioner #(
    parameter int                  NUM_IRQS      = 32,
    parameter logic [NUM_IRQS-1:0] ACTIVE_LOW    = '0,
    parameter int                  FILTER_CYCLES = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_IRQS-1:0] irq_raw_i,
    input  logic [NUM_IRQS-1:0] irq_mask_i,
    output logic [NUM_IRQS-1:0] irq_o,
    output logic [NUM_IRQS-1:0] irq_change_o
);

    // Line 0 is reserved by the PLIC; every other line is live.
    localparam logic [NUM_IRQS-1:0] c_LINE_EN = {{(NUM_IRQS-1){1'b1}}, 1'b0};

    logic [NUM_IRQS-1:0] r_sync1;
    logic [NUM_IRQS-1:0] r_sync2;
    logic [NUM_IRQS-1:0] w_filt_src;
    logic [NUM_IRQS-1:0] w_filt_d;
    logic [NUM_IRQS-1:0] r_filt;
    logic [NUM_IRQS-1:0] r_change;

`ifdef IRQ_SYNC_3FF_EN
    logic [NUM_IRQS-1:0] r_sync3;

    // Synchroniser chain, three stages; polarity is fixed before the first flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= irq_raw_i ^ ACTIVE_LOW;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_filt_src = r_sync3;
`else
    // Synchroniser chain, two stages; polarity is fixed before the first flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_raw_i ^ ACTIVE_LOW;
            r_sync2 <= r_sync1;
        end
    end

    assign w_filt_src = r_sync2;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQS; gi = gi + 1) begin : g_line
            if (FILTER_CYCLES == 0) begin : g_nofilt
                // No stability requirement: the filter simply follows the synchroniser.
                assign w_filt_d[gi] = w_filt_src[gi];
            end else begin : g_filt
                localparam int CNT_W = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES + 1);
                localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

                logic [CNT_W-1:0] r_cnt;
                logic [CNT_W-1:0] w_cnt_d;
                logic             w_filt_bit;

                // Count consecutive cycles the input differs from the filtered value;
                // any return to the filtered value restarts the count from zero.
                always_comb begin
                    w_filt_bit = r_filt[gi];
                    w_cnt_d    = r_cnt;
                    if (w_filt_src[gi] == r_filt[gi]) begin
                        w_cnt_d = '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        w_filt_bit = w_filt_src[gi];
                        w_cnt_d    = '0;
                    end else begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                end

                // Stability counter register.
                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= w_cnt_d;
                    end
                end

                assign w_filt_d[gi] = w_filt_bit;
            end
        end
    endgenerate

    // Filtered level and its one-cycle change strobe, aligned with each other.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_filt   <= '0;
            r_change <= '0;
        end else begin
            r_filt   <= w_filt_d;
            r_change <= (w_filt_d ^ r_filt) & c_LINE_EN;
        end
    end

    // Mask is applied after the register so unmasking a held line takes effect at once.
    assign irq_o        = r_filt & irq_mask_i & c_LINE_EN;
    assign irq_change_o = r_change;

endmodule
`default_nettype wire

// File: tb/tb_irq_source_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_source_conditioner
//  Purpose  : Directed self-checking bench for irq_source_conditioner.
//             DUT A: FILTER_CYCLES=4, line 8 active-low.
//             DUT B: FILTER_CYCLES=0, all lines active-high.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irq_source_conditioner;

`ifdef IRQ_SYNC_3FF_EN
    localparam int c_SYNC = 3;
`else
    localparam int c_SYNC = 2;
`endif
    localparam int c_N    = 4;
    localparam int c_LAT  = c_SYNC + c_N;   // edges from raw change to filtered change, DUT A
    localparam int c_LATB = c_SYNC + 1;     // same for the unfiltered DUT B

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] raw_a, mask_a, irq_a, chg_a;
    logic [31:0] raw_b, mask_b, irq_b, chg_b;

    int n_checks = 0;
    int n_fail   = 0;

    irq_source_conditioner #(
        .NUM_IRQS      (32),
        .ACTIVE_LOW    (32'h0000_0100),
        .FILTER_CYCLES (c_N)
    ) u_dut_a (
        .clk_i        (clk),
        .rst_i        (rst),
        .irq_raw_i    (raw_a),
        .irq_mask_i   (mask_a),
        .irq_o        (irq_a),
        .irq_change_o (chg_a)
    );

    irq_source_conditioner #(
        .NUM_IRQS      (32),
        .ACTIVE_LOW    (32'h0),
        .FILTER_CYCLES (0)
    ) u_dut_b (
        .clk_i        (clk),
        .rst_i        (rst),
        .irq_raw_i    (raw_b),
        .irq_mask_i   (mask_b),
        .irq_o        (irq_b),
        .irq_change_o (chg_b)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        raw_a  = 32'h0000_0100;   // line 8 is active-low: raw 1 means inactive
        raw_b  = 32'h0;
        mask_a = 32'hFFFF_FFFF;
        mask_b = 32'hFFFF_FFFF;
        tick(2);
        check("reset_irq_a", irq_a, 32'h0);
        check("reset_chg_a", chg_a, 32'h0);
        check("reset_irq_b", irq_b, 32'h0);
        check("reset_chg_b", chg_b, 32'h0);

        rst = 1'b0;
        tick(10);
        check("al_idle_irq_a", irq_a, 32'h0);

        // Line 5 held high: rises after exactly c_LAT edges, one change pulse.
        raw_a[5] = 1'b1;
        tick(c_LAT - 1);
        check("l5_before", irq_a, 32'h0);
        tick();
        check("l5_rise_irq", irq_a, 32'h0000_0020);
        check("l5_rise_chg", chg_a, 32'h0000_0020);
        tick();
        check("l5_hold_irq", irq_a, 32'h0000_0020);
        check("l5_hold_chg", chg_a, 32'h0);

        // Line 7: 3-cycle pulse is shorter than the filter and must vanish.
        raw_a[7] = 1'b1; tick(3); raw_a[7] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("l7_short_irq", irq_a, 32'h0000_0020);
            check("l7_short_chg", chg_a, 32'h0);
            tick();
        end
        // Pulses 3,1,3 with 1-cycle gaps: each gap restarts the count.
        raw_a[7] = 1'b1; tick(3); raw_a[7] = 1'b0; tick(1);
        raw_a[7] = 1'b1; tick(1); raw_a[7] = 1'b0; tick(1);
        raw_a[7] = 1'b1; tick(3); raw_a[7] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            check("l7_train_irq", irq_a, 32'h0000_0020);
            check("l7_train_chg", chg_a, 32'h0);
            tick();
        end

        // Line 8 active-low: driving raw low asserts it after c_LAT edges.
        raw_a[8] = 1'b0;
        tick(c_LAT - 1);
        check("l8_before", irq_a, 32'h0000_0020);
        tick();
        check("l8_rise_irq", irq_a, 32'h0000_0120);
        check("l8_rise_chg", chg_a, 32'h0000_0100);

        // Line 3 filtered high, then mask toggled without a clock edge.
        raw_a[3] = 1'b1;
        tick(c_LAT + 1);
        check("l3_high", irq_a, 32'h0000_0128);
        mask_a[3] = 1'b0;
        #1;
        check("l3_masked_now", irq_a, 32'h0000_0120);
        tick(2);
        check("l3_masked_irq", irq_a, 32'h0000_0120);
        check("l3_masked_chg", chg_a, 32'h0);
        mask_a[3] = 1'b1;
        #1;
        check("l3_unmask_now", irq_a, 32'h0000_0128);
        check("l3_unmask_chg", chg_a, 32'h0);
        tick();
        check("l3_unmask_chg2", chg_a, 32'h0);

        // All lines active: bit 0 must stay clear.
        raw_a = 32'hFFFF_FEFF;
        tick(c_LAT);
        check("all_irq_a", irq_a, 32'hFFFF_FFFE);
        check("all_chg_a", chg_a, 32'hFFFF_FED6);

        // Drop everything, then reset in the middle of a fresh count.
        raw_a = 32'h0000_0100;
        tick(c_LAT + 1);
        check("all_low_irq_a", irq_a, 32'h0);
        raw_a = 32'hFFFF_FEFF;
        tick(c_SYNC + 1);
        rst = 1'b1;
        tick();
        check("midrst_irq_a", irq_a, 32'h0);
        check("midrst_chg_a", chg_a, 32'h0);
        rst = 1'b0;
        tick(c_LAT - 1);
        check("post_rst_before", irq_a, 32'h0);
        tick();
        check("post_rst_irq", irq_a, 32'hFFFF_FFFE);
        check("post_rst_chg", chg_a, 32'hFFFF_FFFE);

        // DUT B (no filter): single-cycle pulse on line 4 passes through intact.
        raw_b[4] = 1'b1; tick(); raw_b[4] = 1'b0;
        for (int k = 2; k <= c_LATB + 1; k++) begin
            tick();
            check("b_pulse_irq", irq_b, (k == c_LATB) ? 32'h0000_0010 : 32'h0);
            check("b_pulse_chg", chg_b, (k >= c_LATB) ? 32'h0000_0010 : 32'h0);
        end
        tick();
        check("b_pulse_tail", chg_b, 32'h0);

        raw_b = 32'hFFFF_FFFF;
        tick(c_LATB - 1);
        check("b_all_before", irq_b, 32'h0);
        tick();
        check("b_all_irq", irq_b, 32'hFFFF_FFFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
